ahblite_sram_ctrl: RTL and testbench
====================================

// Module: ahblite_sram_ctrl
// PURPOSE
//  AHB-Lite slave bridging the system bus to a single-port on-chip RAM (distributed or block SRAM).
//  Next-generation RAM slave: configurable memory read latency with inserted wait states,
//  address-correct byte-lane strobes, and two-cycle ERROR responses.
//  Sits behind the AHB decoder/mux; the RAM macro sits outside on the MEM_* ports.
// PARAMETERS
//  ADDR_WIDTH   14  word-address bits; byte window = 2^(ADDR_WIDTH+2); higher HADDR bits alias
//  RD_LATENCY   1   MEM_RDATA valid this many cycles after MEM_CE (0=async/distributed RAM; legal 0..3)
// PORTS
//  HCLK        in   1            bus clock
//  HRESETn     in   1            reset, asynchronous, active-low
//  HSEL        in   1            slave select
//  HADDR       in   32           byte address (address phase)
//  HTRANS      in   2            transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start an access
//  HSIZE       in   3            0=byte, 1=half, 2=word; others -> ERROR
//  HWRITE      in   1            1=write
//  HWDATA      in   32           write data (data phase)
//  HREADY      in   1            bus ready; address phase sampled only when high
//  HREADYOUT   out  1            slave ready
//  HRDATA      out  32           read data
//  HRESP       out  1            0=OKAY, 1=ERROR
//  MEM_ADDR    out  ADDR_WIDTH   RAM word address, registered
//  MEM_CE      out  1            RAM read enable, one-cycle pulse per read
//  MEM_WE      out  4            RAM byte write enables
//  MEM_WDATA   out  32           RAM write data (= HWDATA)
//  MEM_RDATA   in   32           RAM read data
// BEHAVIOUR
//  Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, MEM_CE=0, MEM_WE=0, MEM_ADDR=0.
//   Reset mid-transfer abandons it (no partial write, no pending wait state).
//  accept = HSEL & HTRANS[1] & HREADY. On accept, register word address HADDR[ADDR_WIDTH+1:2],
//   HWRITE, and the byte strobes.
//  Strobes: byte 4'b0001<<HADDR[1:0]; half 4'b0011<<{HADDR[1],1'b0}; word 4'hF.
//  Illegal: HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0 -> ERROR; no RAM access at all.
//  FSM states: IDLE, WRITE, RDWAIT, RDLAST, ERR1, ERR2.
//  - IDLE: HREADYOUT=1, HRESP=0. Non-accepted/IDLE/BUSY cycles stay here.
//  - WRITE (1 cycle, zero wait): MEM_WE=strobes, MEM_ADDR=latched, MEM_WDATA=HWDATA, HREADYOUT=1.
//  - Read data phase lasts RD_LATENCY+1 cycles:
//    - MEM_CE=1 in the first data-phase cycle only.
//    - RDWAIT: HREADYOUT=0; down-counter loaded RD_LATENCY-1, exits at 0. Skipped when RD_LATENCY=0.
//    - RDLAST: HREADYOUT=1, HRDATA=MEM_RDATA (full word; master selects lanes).
//  - HRDATA=0 in every non-RDLAST cycle.
//  - ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1. Then IDLE or the next accepted transfer.
//  Pipelining: in any cycle with HREADYOUT=1 a new accept goes straight to its first state (no bubble).
//   HREADY is low during own wait states, so nothing new is accepted mid-transfer.
//  Write followed directly by read of the same address: the write completes in its data phase
//   before the read issues MEM_CE, so the read returns the new data; no forwarding path needed.
//  MEM_ADDR holds its last value when idle. MEM_WE=0 outside WRITE.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS codes, HSIZE codes, HRESP_OKAY/ERROR, FSM state enum.
//  Sub-module ahb_lane_decode: combinational HSIZE+HADDR[1:0] -> strobe[3:0], illegal flag.
//   Reused by other AHB slaves.
// TESTING
//  1 Byte write HADDR=0x0003, HWDATA=0xAABBCCDD -> MEM_WE=4'b1000 one cycle, MEM_ADDR=0, HREADYOUT=1.
//  2 RD_LATENCY=2: word write 0x10=0x12345678 then back-to-back read 0x10 -> MEM_CE pulse,
//    2 cycles HREADYOUT=0, HRDATA=0x12345678 on the 3rd.
//  3 Half write at 0x0001 -> HREADYOUT 0 then 1 with HRESP=1 both cycles, MEM_WE stays 0.
//    HSIZE=3 read gives the same and no MEM_CE.
//  4 RD_LATENCY=0: read, write, read alternating every cycle -> no wait states, data correct each read.
//  5 HTRANS=BUSY, or HSEL=0, or HREADY=0 with valid HTRANS -> no MEM_CE/MEM_WE, HREADYOUT=1.
//  6 HRESETn low during RDWAIT -> next cycle HREADYOUT=1, MEM_CE=0, state IDLE; the next read works.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer codes and RAM slave FSM states
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {IDLE, WRITE, RDWAIT, RDLAST, ERR1, ERR2} state_t;
endpackage

// File: rtl/ahblite_sram_ctrl_if.sv
// ahblite_sram_ctrl_if: AHB-Lite bus signals between master side and the RAM slave
interface ahblite_sram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  modport master (output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
                  input HREADYOUT, HRDATA, HRESP);
  modport slave (input HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
                 output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/ahb_lane_decode.sv
// ahb_lane_decode: HSIZE + low address bits to byte strobes and misalignment/size error flag
module ahb_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       illegal
);
  always_comb begin
    illegal = (hsize > HSIZE_WORD) || (hsize == HSIZE_HALF && addr[0]) ||
              (hsize == HSIZE_WORD && addr != 2'b00);
    strb = hsize == HSIZE_BYTE ? 4'b0001 << addr :
           hsize == HSIZE_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'hF;
  end
endmodule

// File: rtl/ahblite_sram_ctrl.sv
// ahblite_sram_ctrl: AHB-Lite slave driving a single-port RAM with configurable read latency
module ahblite_sram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahblite_sram_ctrl_if.slave    ahb,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_CE,
  output logic [3:0]            MEM_WE,
  output logic [31:0]           MEM_WDATA,
  input  logic [31:0]           MEM_RDATA
);
  localparam logic [1:0] CNT_INIT = RD_LATENCY == 0 ? 2'd0 : 2'(RD_LATENCY - 1);
  state_t     state;
  logic [1:0] cnt;
  logic       hready_q, hresp_q, accept, illegal;
  logic [3:0] strb;
  logic       unused;
  ahb_lane_decode u_lane (.hsize(ahb.HSIZE), .addr(ahb.HADDR[1:0]), .strb(strb), .illegal(illegal));
  assign accept = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign ahb.HREADYOUT = hready_q;
  assign ahb.HRESP = hresp_q;
  // Read data passes straight through so a zero-latency RAM completes in one cycle
  assign ahb.HRDATA = state == RDLAST ? MEM_RDATA : 32'h0;
  assign MEM_WDATA = ahb.HWDATA;
  assign unused = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      MEM_CE   <= 1'b0;
      MEM_WE   <= 4'h0;
      MEM_ADDR <= '0;
    end else begin
      MEM_CE <= 1'b0;
      MEM_WE <= 4'h0;
      if (state == RDWAIT) begin
        if (cnt == 2'd0) begin
          state    <= RDLAST;
          hready_q <= 1'b1;
        end else cnt <= cnt - 2'd1;
      end else if (state == ERR1) begin
        state    <= ERR2;
        hready_q <= 1'b1;
      end else if (accept && illegal) begin
        state    <= ERR1;
        hready_q <= 1'b0;
        hresp_q  <= HRESP_ERROR;
      end else if (accept) begin
        MEM_ADDR <= ahb.HADDR[ADDR_WIDTH+1:2];
        hresp_q  <= HRESP_OKAY;
        if (ahb.HWRITE) begin
          state    <= WRITE;
          hready_q <= 1'b1;
          MEM_WE   <= strb;
        end else begin
          state    <= RD_LATENCY == 0 ? RDLAST : RDWAIT;
          hready_q <= RD_LATENCY == 0;
          MEM_CE   <= 1'b1;
          cnt      <= CNT_INIT;
        end
      end else begin
        state    <= IDLE;
        hready_q <= 1'b1;
        hresp_q  <= HRESP_OKAY;
      end
    end
endmodule

// File: tb/tb_ahblite_sram_ctrl.sv
// tb_ahblite_sram_ctrl: directed checks of the AHB-Lite RAM slave at read latencies 2 and 0
module tb_ahblite_sram_ctrl;
  import ahb_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic hsel = 1'b0, hwrite = 1'b0, hold = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0] htrans = HTRANS_IDLE;
  logic [2:0] hsize = HSIZE_WORD;
  int tgt = 2;
  int checks = 0, errors = 0;
  ahblite_sram_ctrl_if b2 ();
  ahblite_sram_ctrl_if b0 ();
  logic [13:0] a2, a0;
  logic ce2, ce0;
  logic [3:0] we2, we0;
  logic [31:0] wd2, wd0, rd2, rd0, r1;
  logic [31:0] mem2 [256];
  logic [31:0] mem0 [256];
  always #5 clk = ~clk;
  assign b2.HSEL = hsel & (tgt == 2);
  assign b0.HSEL = hsel & (tgt == 0);
  assign b2.HADDR = haddr;   assign b0.HADDR = haddr;
  assign b2.HTRANS = htrans; assign b0.HTRANS = htrans;
  assign b2.HSIZE = hsize;   assign b0.HSIZE = hsize;
  assign b2.HWRITE = hwrite; assign b0.HWRITE = hwrite;
  assign b2.HWDATA = hwdata; assign b0.HWDATA = hwdata;
  assign b2.HREADY = b2.HREADYOUT & ~hold;
  assign b0.HREADY = b0.HREADYOUT & ~hold;
  ahblite_sram_ctrl #(.ADDR_WIDTH(14), .RD_LATENCY(2)) u2 (
    .HCLK(clk), .HRESETn(rstn), .ahb(b2), .MEM_ADDR(a2), .MEM_CE(ce2),
    .MEM_WE(we2), .MEM_WDATA(wd2), .MEM_RDATA(rd2));
  ahblite_sram_ctrl #(.ADDR_WIDTH(14), .RD_LATENCY(0)) u0 (
    .HCLK(clk), .HRESETn(rstn), .ahb(b0), .MEM_ADDR(a0), .MEM_CE(ce0),
    .MEM_WE(we0), .MEM_WDATA(wd0), .MEM_RDATA(rd0));
  // RAM models: latency-2 synchronous for u2, asynchronous for u0
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we2[i]) mem2[a2[7:0]][8*i+:8] <= wd2[8*i+:8];
      if (we0[i]) mem0[a0[7:0]][8*i+:8] <= wd0[8*i+:8];
    end
    if (ce2) r1 <= mem2[a2[7:0]];
    rd2 <= r1;
  end
  assign rd0 = mem0[a0[7:0]];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz, input logic wr);
    hsel = 1'b1; htrans = tr; haddr = a; hsize = sz; hwrite = wr;
  endtask
  task automatic idle();
    hsel = 1'b0; htrans = HTRANS_IDLE;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem2[i] = '0;
      mem0[i] = '0;
    end
    r1 = '0;
    rd2 = '0;
    cyc(); cyc();
    chk("rst_hreadyout", 32'(b2.HREADYOUT), 1);
    chk("rst_hresp", 32'(b2.HRESP), 0);
    chk("rst_hrdata", b2.HRDATA, 0);
    chk("rst_ce", 32'(ce2), 0);
    chk("rst_we", 32'(we2), 0);
    chk("rst_addr", 32'(a2), 0);
    rstn = 1'b1;
    cyc();
    xfer(HTRANS_NONSEQ, 32'h3, HSIZE_BYTE, 1'b1);
    cyc();
    chk("t1_we", 32'(we2), 32'h8);
    chk("t1_addr", 32'(a2), 0);
    chk("t1_ready", 32'(b2.HREADYOUT), 1);
    hwdata = 32'hAABBCCDD;
    xfer(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1);
    cyc();
    chk("t2_we", 32'(we2), 32'hF);
    chk("t2_addr", 32'(a2), 4);
    hwdata = 32'h12345678;
    xfer(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
    cyc();
    chk("t2_ce", 32'(ce2), 1);
    chk("t2_wait1", 32'(b2.HREADYOUT), 0);
    chk("t2_rdata0", b2.HRDATA, 0);
    chk("t2_we_off", 32'(we2), 0);
    idle();
    cyc();
    chk("t2_ce_pulse", 32'(ce2), 0);
    chk("t2_wait2", 32'(b2.HREADYOUT), 0);
    cyc();
    chk("t2_last_ready", 32'(b2.HREADYOUT), 1);
    chk("t2_rdata", b2.HRDATA, 32'h12345678);
    xfer(HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 1'b0);
    cyc(); idle(); cyc(); cyc();
    chk("t1_byte_lane", b2.HRDATA, 32'hAA000000);
    xfer(HTRANS_NONSEQ, 32'h1, HSIZE_HALF, 1'b1);
    cyc();
    chk("t3_err1_ready", 32'(b2.HREADYOUT), 0);
    chk("t3_err1_resp", 32'(b2.HRESP), 1);
    chk("t3_err1_we", 32'(we2), 0);
    idle();
    cyc();
    chk("t3_err2_ready", 32'(b2.HREADYOUT), 1);
    chk("t3_err2_resp", 32'(b2.HRESP), 1);
    chk("t3_err2_we", 32'(we2), 0);
    cyc();
    chk("t3_okay", 32'(b2.HRESP), 0);
    xfer(HTRANS_NONSEQ, 32'h0, 3'd3, 1'b0);
    cyc();
    chk("t3_sz3_ready", 32'(b2.HREADYOUT), 0);
    chk("t3_sz3_resp", 32'(b2.HRESP), 1);
    chk("t3_sz3_ce", 32'(ce2), 0);
    idle();
    cyc();
    chk("t3_sz3_ready2", 32'(b2.HREADYOUT), 1);
    chk("t3_sz3_resp2", 32'(b2.HRESP), 1);
    chk("t3_sz3_ce2", 32'(ce2), 0);
    cyc();
    xfer(HTRANS_BUSY, 32'h10, HSIZE_WORD, 1'b0);
    cyc();
    chk("t5_busy_ce", 32'(ce2), 0);
    chk("t5_busy_ready", 32'(b2.HREADYOUT), 1);
    xfer(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1);
    hsel = 1'b0;
    cyc();
    chk("t5_nosel_we", 32'(we2), 0);
    xfer(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
    hold = 1'b1;
    cyc();
    chk("t5_hold_ce", 32'(ce2), 0);
    chk("t5_hold_ready", 32'(b2.HREADYOUT), 1);
    hold = 1'b0;
    cyc();
    idle();
    chk("t6_ce", 32'(ce2), 1);
    chk("t6_wait", 32'(b2.HREADYOUT), 0);
    #2 rstn = 1'b0;
    cyc();
    chk("t6_rst_ready", 32'(b2.HREADYOUT), 1);
    chk("t6_rst_ce", 32'(ce2), 0);
    chk("t6_rst_state", 32'(u2.state), 32'(IDLE));
    rstn = 1'b1;
    xfer(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
    cyc(); idle(); cyc(); cyc();
    chk("t6_read_after", b2.HRDATA, 32'h12345678);
    chk("t6_read_ready", 32'(b2.HREADYOUT), 1);
    tgt = 0;
    cyc();
    xfer(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b1);
    cyc();
    chk("t4_we", 32'(we0), 32'hF);
    chk("t4_addr", 32'(a0), 8);
    hwdata = 32'hCAFEF00D;
    xfer(HTRANS_SEQ, 32'h20, HSIZE_WORD, 1'b0);
    cyc();
    chk("t4_rd1_ready", 32'(b0.HREADYOUT), 1);
    chk("t4_rd1_ce", 32'(ce0), 1);
    chk("t4_rd1", b0.HRDATA, 32'hCAFEF00D);
    xfer(HTRANS_NONSEQ, 32'h24, HSIZE_WORD, 1'b1);
    cyc();
    chk("t4_wr_addr", 32'(a0), 9);
    chk("t4_wr_rdata0", b0.HRDATA, 0);
    hwdata = 32'h0BADBEEF;
    xfer(HTRANS_NONSEQ, 32'h24, HSIZE_WORD, 1'b0);
    cyc();
    chk("t4_rd2", b0.HRDATA, 32'h0BADBEEF);
    chk("t4_rd2_ready", 32'(b0.HREADYOUT), 1);
    xfer(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b1);
    cyc();
    hwdata = 32'h11112222;
    xfer(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0);
    cyc();
    chk("t4_rd3", b0.HRDATA, 32'h11112222);
    idle();
    cyc();
    chk("t4_idle_rdata", b0.HRDATA, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
